ladder_ctrl: RTL and testbench
==============================

# ladder_ctrl

Sequencer for the ladder up/down counter datapath. It accepts a queue of rung heights (delta values) from a requester over a valid/ready handshake. For each queued delta it drives the count up from 0 to delta and back down to 0, then pulses completion and loads the next delta. It sits between the configuration requester and the ladder count consumer, owning the count and direction state.

## Interface
- DW, 3: delta width
- CW, 4: count width; CW >= DW required
- DEPTH, 4: delta queue entries, power of two, >= 2
- HOLD, 2: peak dwell cycles, >= 1; used only with LADDER_PEAK_HOLD_EN
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- delta_valid  in  1  requester offers delta_data
- delta_data  in  DW  rung height
- delta_ready  out  1  queue not full and abort low; push occurs when valid && ready
- enable  in  1  0 freezes state machine and count; queue pushes still accepted
- abort  in  1  synchronous flush
- count  out  CW  current ladder count
- direction  out  1  1 = up, 0 = down
- busy  out  1  high in LOAD/UP/PEAK/DOWN
- peak  out  1  high while count == active delta in UP (top cycle), PEAK or DOWN entry
- rung_done  out  1  one-cycle pulse, ladder returned to 0
- fifo_level  out  $clog2(DEPTH+1)  queued entries

## Operation
- States: IDLE, LOAD, UP, PEAK (macro only), DOWN.
- IDLE: count=0, direction=1. If queue non-empty and enable → pop head, go LOAD.
- LOAD: active delta register holds popped value. Next state depends on the delta:
  - delta==0 → IDLE with rung_done=1, count stays 0.
  - Otherwise → UP.
- UP: count += 1 per enabled cycle. On the edge where count becomes delta:
  - Without macro → DOWN, direction=0.
  - With macro → PEAK.
- PEAK: count held at delta for HOLD enabled cycles → DOWN, direction=0.
- DOWN: count -= 1 per enabled cycle. On the edge where count becomes 0:
  - rung_done=1, direction=1, → IDLE.
- Arithmetic: count zero-extended from DW; never exceeds 2^DW-1, never wraps.
- Queue: full ⇒ delta_ready=0, push dropped by protocol. A pop and a push in the same cycle are both honoured. fifo_level updates registered.
- abort (priority over enable, below reset): next edge count=0, direction=1, state IDLE, queue emptied, active delta cleared, no rung_done; the same-cycle push is ignored.
- enable=0: state, count, direction, PEAK dwell counter frozen; rung_done and LOAD not generated.

## Timing
- Reset values: count 0, direction 1, busy 0, peak 0, rung_done 0, delta_ready 1, fifo_level 0.
- All outputs registered or decoded from registers only; no combinational input→output path except delta_ready←abort.
- Delta pushed at edge t: IDLE sees non-empty at t+1, LOAD after edge t+1, first count=1 after edge t+2.
- Ladder of D>0, enable held high:
  - 2D+1 cycles LOAD→IDLE.
  - Back-to-back period 2D+2 cycles; with macro, 2D+2+HOLD.
- rung_done coincides with first cycle of count==0 after DOWN.

## Configuration
- LADDER_PEAK_HOLD_EN defined: PEAK state exists; count dwells at delta for HOLD extra cycles, peak high throughout.
- Not defined: no PEAK state or dwell counter; count turns around immediately (…,D-1,D,D-1,…); HOLD unused.

## Structure
- Package ladder_pkg: state enum ladder_state_e, default DW/CW/DEPTH/HOLD localparams.
- Sub-module ladder_delta_fifo: synchronous FIFO with push/pop/flush, full/empty, level; ladder_ctrl holds the FSM and counter.

## Test plan
- Reset, push 3, enable=1 → count after LOAD: 1,2,3,2,1,0; direction falls with count=2; rung_done with final 0; busy 7 cycles.
- Push 0 → busy for one LOAD cycle, rung_done pulse, count stays 0.
- enable=0, push 4 deltas → fifo_level 4, delta_ready 0, 5th valid not accepted; enable=1 → level 3 after first pop.
- Delta 5, drop enable at count 2 for 3 cycles → count holds 2, direction 1; resumes to 3.
- Two queued, abort during DOWN at count 2 → next cycle count 0, fifo_level 0, busy 0, no rung_done.
- LADDER_PEAK_HOLD_EN, HOLD=2, delta 2 → count 1,2,2,2,1,0; peak high 3 cycles; reset mid-UP → all outputs to reset values immediately.

Source files
------------

// File: rtl/ladder_pkg.sv
// Shared types and default sizing for the ladder sequencer.
// LADDER_PEAK_HOLD_EN adds the PEAK dwell state to the state enum.
package ladder_pkg;

    localparam int unsigned DEF_DW    = 3;
    localparam int unsigned DEF_CW    = 4;
    localparam int unsigned DEF_DEPTH = 4;
    localparam int unsigned DEF_HOLD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_UP,
        ST_DOWN
`ifdef LADDER_PEAK_HOLD_EN
        ,
        ST_PEAK
`endif
    } ladder_state_e;

endpackage

// File: rtl/ladder_delta_fifo.sv
// Synchronous delta queue with push/pop/flush and registered occupancy.
// DEPTH must be a power of two so the pointers wrap naturally.
module ladder_delta_fifo #(
    parameter int unsigned DW    = 3,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [DW-1:0] head,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DW-1:0] mem [0:DEPTH-1];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_q;
    logic          do_push;
    logic          do_pop;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];
    assign level   = level_q;

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/ladder_ctrl.sv
// Ladder sequencer: pops rung heights from a queue and counts 0->delta->0.
// LADDER_PEAK_HOLD_EN adds a PEAK state that dwells HOLD cycles at the top.
module ladder_ctrl
    import ladder_pkg::*;
#(
    parameter int unsigned DW    = DEF_DW,
    parameter int unsigned CW    = DEF_CW,
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned HOLD  = DEF_HOLD
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       delta_valid,
    input  logic [DW-1:0]              delta_data,
    output logic                       delta_ready,
    input  logic                       enable,
    input  logic                       abort,
    output logic [CW-1:0]              count,
    output logic                       direction,
    output logic                       busy,
    output logic                       peak,
    output logic                       rung_done,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level
);

    localparam int unsigned LW = $clog2(DEPTH + 1);

    // Illegal parameter combinations leave this hook elaborated for inspection.
    if (CW < DW || DEPTH < 2 || HOLD < 1) begin : g_bad_params
    end

    ladder_state_e state;
    logic [DW-1:0] active;
    logic [CW-1:0] count_q;
    logic          dir_q;
    logic          done_q;
    logic [DW-1:0] head;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          at_top;
    logic          last_step;

`ifdef LADDER_PEAK_HOLD_EN
    localparam int unsigned HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    logic [HW-1:0] hold_cnt;
`endif

    assign delta_ready = !full && !abort;
    assign push        = delta_valid && delta_ready;
    assign pop         = enable && !abort && (state == ST_IDLE) && !empty;
    assign at_top      = (count_q == CW'(active));
    assign last_step   = (count_q == CW'(1));

    ladder_delta_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .LW    (LW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (delta_data),
        .pop       (pop),
        .flush     (abort),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .level     (fifo_level)
    );

    // The count==0 cycle after the descent stays busy and carries rung_done;
    // the IDLE cycle that follows is where the next delta may be popped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            active   <= '0;
            count_q  <= '0;
            dir_q    <= 1'b1;
            done_q   <= 1'b0;
`ifdef LADDER_PEAK_HOLD_EN
            hold_cnt <= '0;
`endif
        end else if (abort) begin
            state    <= ST_IDLE;
            active   <= '0;
            count_q  <= '0;
            dir_q    <= 1'b1;
            done_q   <= 1'b0;
`ifdef LADDER_PEAK_HOLD_EN
            hold_cnt <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            if (enable) begin
                case (state)
                    ST_IDLE: begin
                        if (!empty) begin
                            active <= head;
                            state  <= ST_LOAD;
                        end
                    end
                    ST_LOAD: begin
                        if (active == '0) begin
                            state  <= ST_IDLE;
                            done_q <= 1'b1;
                        end else begin
                            state   <= ST_UP;
                            count_q <= CW'(1);
                        end
                    end
                    ST_UP: begin
                        if (at_top) begin
`ifdef LADDER_PEAK_HOLD_EN
                            state    <= ST_PEAK;
                            hold_cnt <= '0;
`else
                            state   <= ST_DOWN;
                            count_q <= count_q - 1'b1;
                            dir_q   <= last_step;
                            done_q  <= last_step;
`endif
                        end else begin
                            count_q <= count_q + 1'b1;
                        end
                    end
`ifdef LADDER_PEAK_HOLD_EN
                    ST_PEAK: begin
                        if (hold_cnt == HW'(HOLD - 1)) begin
                            state   <= ST_DOWN;
                            count_q <= count_q - 1'b1;
                            dir_q   <= last_step;
                            done_q  <= last_step;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
`endif
                    ST_DOWN: begin
                        if (count_q == '0) begin
                            state <= ST_IDLE;
                        end else begin
                            count_q <= count_q - 1'b1;
                            if (last_step) begin
                                dir_q  <= 1'b1;
                                done_q <= 1'b1;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign count     = count_q;
    assign direction = dir_q;
    assign rung_done = done_q;
    assign busy      = (state != ST_IDLE);
`ifdef LADDER_PEAK_HOLD_EN
    assign peak      = ((state == ST_UP) || (state == ST_PEAK) || (state == ST_DOWN)) && at_top;
`else
    assign peak      = ((state == ST_UP) || (state == ST_DOWN)) && at_top;
`endif

endmodule

// File: tb/tb_ladder_ctrl.sv
// Scoreboard bench for ladder_ctrl: a frame-list model predicts every cycle.
// Honours LADDER_PEAK_HOLD_EN when building the expected ladder shape.
module tb_ladder_ctrl;

    localparam int unsigned DW    = 3;
    localparam int unsigned CW    = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned HOLD  = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          delta_valid = 1'b0;
    logic [DW-1:0] delta_data = '0;
    logic          enable = 1'b0;
    logic          abort = 1'b0;
    logic          delta_ready;
    logic [CW-1:0] count;
    logic          direction;
    logic          busy;
    logic          peak;
    logic          rung_done;
    logic [$clog2(DEPTH+1)-1:0] fifo_level;

    ladder_ctrl #(
        .DW    (DW),
        .CW    (CW),
        .DEPTH (DEPTH),
        .HOLD  (HOLD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .delta_valid (delta_valid),
        .delta_data  (delta_data),
        .delta_ready (delta_ready),
        .enable      (enable),
        .abort       (abort),
        .count       (count),
        .direction   (direction),
        .busy        (busy),
        .peak        (peak),
        .rung_done   (rung_done),
        .fifo_level  (fifo_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        int count; int dir; int busy; int peak; int done;
    } frame_t;

    typedef struct {
        int count; int dir; int busy; int peak; int done; int level; int ready;
    } exp_t;

    exp_t        exp_q[$];
    frame_t      plan[$];
    frame_t      cur;
    int unsigned fq[$];
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    function automatic frame_t mk(int c, int d, int b, int p, int dn);
        frame_t f;
        f.count = c; f.dir = d; f.busy = b; f.peak = p; f.done = dn;
        return f;
    endfunction

    // Whole ladder as a list of per-cycle output frames, starting at LOAD.
    function automatic void build(int unsigned d);
        plan.push_back(mk(0, 1, 1, 0, 0));
        if (d == 0) begin
            plan.push_back(mk(0, 1, 0, 0, 1));
        end else begin
            for (int unsigned c = 1; c <= d; c++) plan.push_back(mk(int'(c), 1, 1, (c == d) ? 1 : 0, 0));
`ifdef LADDER_PEAK_HOLD_EN
            for (int unsigned h = 0; h < HOLD; h++) plan.push_back(mk(int'(d), 1, 1, 1, 0));
`endif
            for (int c = int'(d) - 1; c >= 1; c--) plan.push_back(mk(c, 0, 1, 0, 0));
            plan.push_back(mk(0, 1, 1, 0, 1));
        end
    endfunction

    task automatic model_reset();
        fq.delete();
        plan.delete();
        cur = mk(0, 1, 0, 0, 0);
    endtask

    task automatic model_step(input bit v, input int unsigned d, input bit en, input bit ab);
        bit push_ok;
        if (ab) begin
            model_reset();
            return;
        end
        push_ok = v && (fq.size() < DEPTH);
        if (en) begin
            if (plan.size() > 0) begin
                cur = plan.pop_front();
            end else if (cur.busy == 0 && fq.size() > 0) begin
                build(fq.pop_front());
                cur = plan.pop_front();
            end else begin
                cur = mk(0, 1, 0, 0, 0);
            end
        end else begin
            cur.done = 0;
        end
        if (push_ok) fq.push_back(d);
    endtask

    task automatic cycle(input bit v, input int unsigned d, input bit en, input bit ab);
        exp_t e;
        delta_valid = v;
        delta_data  = DW'(d);
        enable      = en;
        abort       = ab;
        e.count = cur.count; e.dir = cur.dir; e.busy = cur.busy;
        e.peak = cur.peak; e.done = cur.done; e.level = fq.size();
        e.ready = (fq.size() < DEPTH && !ab) ? 1 : 0;
        exp_q.push_back(e);
        @(posedge clk);
        model_step(v, d, en, ab);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("count",       int'(count),       e.count);
            chk("direction",   int'(direction),   e.dir);
            chk("busy",        int'(busy),        e.busy);
            chk("peak",        int'(peak),        e.peak);
            chk("rung_done",   int'(rung_done),   e.done);
            chk("fifo_level",  int'(fifo_level),  e.level);
            chk("delta_ready", int'(delta_ready), e.ready);
        end
    end

    initial begin
        int steps;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Single ladder of 3, then an idle stretch.
        cycle(1, 3, 1, 0);
        repeat (10) cycle(0, 0, 1, 0);

        // Zero-height rung.
        cycle(1, 0, 1, 0);
        repeat (4) cycle(0, 0, 1, 0);

        // Fill the queue while frozen; the fifth offer must be refused.
        for (int unsigned i = 1; i <= 5; i++) cycle(1, i, 0, 0);
        cycle(0, 0, 0, 0);
        repeat (40) cycle(0, 0, 1, 0);

        // Freeze mid-climb at count 2.
        cycle(1, 5, 1, 0);
        steps = 0;
        while (!(cur.busy == 1 && cur.count == 2 && cur.dir == 1) && steps < 10) begin
            cycle(0, 0, 1, 0);
            steps++;
        end
        chk("reach_up_2", steps < 10 ? 1 : 0, 1);
        repeat (3) cycle(0, 0, 0, 0);
        repeat (15) cycle(0, 0, 1, 0);

        // Abort during descent with a second delta waiting.
        cycle(1, 4, 1, 0);
        cycle(1, 3, 1, 0);
        steps = 0;
        while (!(cur.busy == 1 && cur.count == 2 && cur.dir == 0) && steps < 20) begin
            cycle(0, 0, 1, 0);
            steps++;
        end
        chk("reach_down_2", steps < 20 ? 1 : 0, 1);
        cycle(1, 6, 1, 1);
        repeat (4) cycle(0, 0, 1, 0);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom_range(0, 99) < 40) ? 1'b1 : 1'b0,
                  $urandom_range(0, (1 << DW) - 1),
                  ($urandom_range(0, 99) < 85) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
        end
        cycle(0, 0, 1, 1);

        // Asynchronous reset in the middle of a climb.
        cycle(1, 5, 1, 0);
        steps = 0;
        while (!(cur.busy == 1 && cur.count == 2 && cur.dir == 1) && steps < 10) begin
            cycle(1, 2, 1, 0);
            steps++;
        end
        chk("reach_up_2b", steps < 10 ? 1 : 0, 1);
        @(negedge clk);
        #1;
        chk("pre_reset_count", int'(count), 2);
        reset = 1'b1;
        #1;
        chk("rst_count",       int'(count),       0);
        chk("rst_direction",   int'(direction),   1);
        chk("rst_busy",        int'(busy),        0);
        chk("rst_peak",        int'(peak),        0);
        chk("rst_rung_done",   int'(rung_done),   0);
        chk("rst_delta_ready", int'(delta_ready), 1);
        chk("rst_fifo_level",  int'(fifo_level),  0);
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        cycle(1, 2, 1, 0);
        repeat (10) cycle(0, 0, 1, 0);

        @(negedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
